if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the main control decoder in the single-cycle-style MIPS core.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Latches the fetched word and presents its opcode field (op) to the decoder.
- Consumes the decoder's Branch and Jump outputs, plus the ALU Zero flag, to select the next PC.

---
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// latches the instruction for the decoder and selects the next PC.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    output logic [31:0] retired,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [31:0]      pc_nxt, instr_nxt, retired_nxt, next_pc, branch_off;
    logic             err_nxt;

    // Next-PC select: jump beats a taken branch, otherwise sequential.
    always_comb begin
        branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (Jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4 + branch_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_nxt       = pc;
        instr_nxt    = instr;
        retired_nxt  = retired;
        err_nxt      = fetch_err;
        case (state)
            S_FETCH: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    instr_nxt    = imem_rdata;
                    wait_cnt_nxt = '0;
                    state_nxt    = S_EXEC;
                end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_nxt      = next_pc;
                    retired_nxt = retired + 32'd1;
                    state_nxt   = S_FETCH;
                end
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            pc        <= RESET_PC;
            instr     <= '0;
            retired   <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            pc        <= pc_nxt;
            instr     <= instr_nxt;
            retired   <= retired_nxt;
            fetch_err <= err_nxt;
        end
    end

    // Gating with rst drops the request for the whole reset cycle.
    assign imem_req    = (state == S_FETCH) && rst;
    assign imem_addr   = pc;
    assign instr_valid = (state == S_EXEC);
    assign op          = instr[31:26];
    assign pc_plus4    = pc + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage against an instruction-level PC/retire model.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk, rst, imem_req, imem_ack, stall, branch, jump, zero;
    logic        instr_valid, fetch_err;
    logic [31:0] imem_addr, imem_rdata, pc, pc_plus4, instr, retired;
    logic [5:0]  op;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_pc, exp_ret;

    if_stage #(.RESET_PC(RPC), .MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall),
        .Branch(branch), .Jump(jump), .Zero(zero), .pc(pc), .pc_plus4(pc_plus4),
        .instr(instr), .op(op), .instr_valid(instr_valid), .retired(retired),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule computed with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic b, input logic j, input logic z);
        logic [31:0] p4;
        logic [31:0] off;
        p4 = p + 32'd4;
        off = 32'($signed(w[15:0])) * 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (b && z) return p4 + off;
        return p4;
    endfunction

    task automatic test_reset(input int n);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom; stall = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        end
        checks++;
        if (pc !== RPC || instr !== 32'd0 || instr_valid !== 1'b0 || retired !== 32'd0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_state: pc=%h instr=%h valid=%b ret=%0d err=%b want pc=%h zeros",
                     pc, instr, instr_valid, retired, fetch_err, RPC);
        end
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            errors++; $display("FAIL rst_release: req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
        end
        exp_pc = RPC;
        exp_ret = 32'd0;
    endtask

    // Fetch one word after `delay` idle request cycles, hold `stalls` EXEC cycles, then retire.
    task automatic exec_one(input logic [31:0] w, input logic b, input logic j, input logic z,
                            input int stalls, input int delay);
        for (int k = 0; k <= delay; k++) begin
            branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom); stall = 1'($urandom);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL fetch: req=%b addr=%h valid=%b err=%b want 1 %h 0 0",
                         imem_req, imem_addr, instr_valid, fetch_err, exp_pc);
            end
            imem_ack = (k == delay);
            imem_rdata = (k == delay) ? w : $urandom;
            step();
        end
        branch = b; jump = j; zero = z;
        for (int s = 0; s <= stalls; s++) begin
            stall = (s < stalls);
            imem_ack = 1'($urandom);
            imem_rdata = $urandom;
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== w || op !== w[31:26] ||
                pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4 || retired !== exp_ret) begin
                errors++;
                $display("FAIL exec: valid=%b req=%b instr=%h op=%h pc=%h pc4=%h ret=%0d want instr=%h pc=%h ret=%0d",
                         instr_valid, imem_req, instr, op, pc, pc_plus4, retired, w, exp_pc, exp_ret);
            end
            step();
        end
        imem_ack = 1'b0;
        exp_pc = model_next(exp_pc, w, b, j, z);
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (pc !== exp_pc || retired !== exp_ret) begin
            errors++; $display("FAIL retire: pc=%h ret=%0d want %h %0d", pc, retired, exp_pc, exp_ret);
        end
    endtask

    task automatic test_sequential();
        test_reset(2);
        for (int i = 0; i < 3; i++) exec_one($urandom, 1'b0, 1'b0, 1'($urandom), 0, 0);
        checks++;
        if (pc !== 32'h0000_300C || retired !== 32'd3) begin
            errors++; $display("FAIL seq: pc=%h ret=%0d want 0000300c 3", pc, retired);
        end
    endtask

    task automatic test_branch();
        test_reset(1);
        exec_one(32'h1000_0003, 1'b1, 1'b0, 1'b1, 0, 0);
        checks++;
        if (imem_addr !== 32'h0000_3010) begin errors++; $display("FAIL beq_taken: addr=%h want 00003010", imem_addr); end
        test_reset(1);
        exec_one(32'h1000_0003, 1'b1, 1'b0, 1'b0, 0, 0);
        checks++;
        if (imem_addr !== 32'h0000_3004) begin errors++; $display("FAIL beq_not: addr=%h want 00003004", imem_addr); end
        exec_one(32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 0, 1);
        checks++;
        if (pc !== 32'h0000_3000) begin errors++; $display("FAIL beq_back: pc=%h want 00003000", pc); end
    endtask

    task automatic test_jump();
        test_reset(1);
        exec_one(32'h0800_0C10, 1'b1, 1'b1, 1'b1, 0, 0);
        checks++;
        if (pc !== 32'h0000_3040) begin errors++; $display("FAIL jump_prio: pc=%h want 00003040", pc); end
    endtask

    task automatic test_stall();
        test_reset(1);
        exec_one($urandom, 1'b0, 1'b0, 1'b0, 3, 2);
        exec_one(32'h1000_0010, 1'b1, 1'b0, 1'b1, 3, 0);
        checks++;
        if (pc !== 32'h0000_3048 || retired !== 32'd2) begin
            errors++; $display("FAIL stall_adv: pc=%h ret=%0d want 00003048 2", pc, retired);
        end
    endtask

    task automatic test_timeout();
        test_reset(1);
        exec_one($urandom, 1'b0, 1'b0, 1'b0, 0, 15);
        exec_one($urandom, 1'b0, 1'b0, 1'b0, 0, 15);
        test_reset(1);
        imem_ack = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                errors++; $display("FAIL wait: cycle=%0d req=%b err=%b want 1 0", k, imem_req, fetch_err);
            end
            step();
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 ||
                pc !== RPC || retired !== 32'd0) begin
                errors++;
                $display("FAIL err_frozen: err=%b req=%b valid=%b instr=%h pc=%h ret=%0d want 1 0 0 0 %h 0",
                         fetch_err, imem_req, instr_valid, instr, pc, retired, RPC);
            end
            imem_ack = 1'($urandom); imem_rdata = $urandom; stall = 1'($urandom);
            step();
        end
        test_reset(1);
        exec_one($urandom, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_midfetch();
        test_reset(1);
        exec_one($urandom, 1'b0, 1'b0, 1'b0, 0, 0);
        step();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req: req=%b want 0", imem_req); end
        step();
        checks++;
        if (instr !== 32'd0 || pc !== RPC || retired !== 32'd0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst: instr=%h pc=%h ret=%0d valid=%b want 0 %h 0 0",
                               instr, pc, retired, instr_valid, RPC);
        end
        imem_ack = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            errors++; $display("FAIL mid_reissue: req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
        end
        exp_pc = RPC; exp_ret = 32'd0;
        exec_one($urandom, 1'b0, 1'b0, 1'b0, 2, 0);
    endtask

    task automatic test_random();
        logic [31:0] w;
        test_reset(1);
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            exec_one(w, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0;
        exp_pc = RPC; exp_ret = '0;
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_timeout();
        test_reset_midfetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
